// File: rtl/regfile_pkg.sv
// Shared defaults and width helpers for the multi-ported register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned NRD_DEF  = 2;
  localparam int unsigned NWR_DEF  = 1;

  // Address width for a power-of-two register count (2..64), minimum 1.
  function automatic int unsigned aw_of(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i <= 6; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  localparam int unsigned AW_DEF      = aw_of(NREG_DEF);
  // Flattened port widths for the default configuration.
  localparam int unsigned RD_A_W_DEF  = NRD_DEF * AW_DEF;
  localparam int unsigned RD_AV_W_DEF = NRD_DEF * XLEN_DEF;
  localparam int unsigned WR_A_W_DEF  = NWR_DEF * AW_DEF;
  localparam int unsigned WR_AV_W_DEF = NWR_DEF * XLEN_DEF;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Priority per bit: reserve sets > write clears > flush clears > hold.
// Register 0 never becomes busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NWR  = NWR_DEF,
  localparam int unsigned AW  = aw_of(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_a,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_a,
  output logic [NREG-1:0]   busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector: flush/clear first, then reserve so it overrides both.
  always_comb begin
    busy_d = flush ? '0 : busy_q;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wr_en[j]) busy_d[wr_a[j*AW +: AW]] = 1'b0;
    end
    if (rsv_en) busy_d[rsv_a] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with captured read addresses and a pending-write
// scoreboard. x0 is hardwired zero.
// Optional macro REGFILE_MP_BYPASS_EN: forwards same-cycle writes to read data.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = NRD_DEF,
  parameter int unsigned NWR  = NWR_DEF,
  localparam int unsigned AW  = aw_of(NREG)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                FLUSH,
  input  logic                STALL,
  input  logic [NRD*AW-1:0]   REG_IR_I_A,
  output logic [NRD*AW-1:0]   REG_IR_O_A,
  output logic [NRD*XLEN-1:0] REG_IR_O_AV,
  output logic [NRD-1:0]      REG_IR_O_BUSY,
  input  logic [NWR-1:0]      REG_IW_I_EN,
  input  logic [NWR*AW-1:0]   REG_IW_I_A,
  input  logic [NWR*XLEN-1:0] REG_IW_I_AV,
  input  logic                REG_RSV_I_EN,
  input  logic [AW-1:0]       REG_RSV_I_A
);

  logic [XLEN-1:0]   regs_q [NREG];
  logic [XLEN-1:0]   regs_d [NREG];
  logic [NRD*AW-1:0] addr_q;
  logic [NRD*AW-1:0] addr_d;
  logic [NREG-1:0]   busy;

  // Array update: later write ports overwrite earlier ones on collision.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (REG_IW_I_EN[j] && (REG_IW_I_A[j*AW +: AW] != '0))
        regs_d[REG_IW_I_A[j*AW +: AW]] = REG_IW_I_AV[j*XLEN +: XLEN];
    end
  end

  // Captured read addresses: flush clears, stall holds.
  always_comb begin
    if (FLUSH)      addr_d = '0;
    else if (STALL) addr_d = addr_q;
    else            addr_d = REG_IR_I_A;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      addr_q <= '0;
    end else begin
      regs_q <= regs_d;
      addr_q <= addr_d;
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk    (CLK),
    .rst    (RST),
    .flush  (FLUSH),
    .rsv_en (REG_RSV_I_EN),
    .rsv_a  (REG_RSV_I_A),
    .wr_en  (REG_IW_I_EN),
    .wr_a   (REG_IW_I_A),
    .busy   (busy)
  );

  assign REG_IR_O_A = addr_q;

  // Read ports: array/scoreboard lookup by captured address, optional forwarding.
  always_comb begin
    REG_IR_O_AV   = '0;
    REG_IR_O_BUSY = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      if (addr_q[k*AW +: AW] != '0) begin
        REG_IR_O_AV[k*XLEN +: XLEN] = regs_q[addr_q[k*AW +: AW]];
        REG_IR_O_BUSY[k]            = busy[addr_q[k*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
        for (int unsigned j = 0; j < NWR; j++) begin
          if (REG_IW_I_EN[j] && (REG_IW_I_A[j*AW +: AW] == addr_q[k*AW +: AW])) begin
            REG_IR_O_AV[k*XLEN +: XLEN] = REG_IW_I_AV[j*XLEN +: XLEN];
            REG_IR_O_BUSY[k]            = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-style bench for regfile_mp (NRD=2, NWR=2, XLEN=32, NREG=32).
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, stall;
  logic [9:0]  ir_i_a;
  logic [9:0]  ir_o_a;
  logic [63:0] ir_o_av;
  logic [1:0]  ir_o_busy;
  logic [1:0]  iw_en;
  logic [9:0]  iw_a;
  logic [63:0] iw_av;
  logic        rsv_en;
  logic [4:0]  rsv_a;

  regfile_mp #(
    .XLEN (32),
    .NREG (32),
    .NRD  (2),
    .NWR  (2)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .FLUSH         (flush),
    .STALL         (stall),
    .REG_IR_I_A    (ir_i_a),
    .REG_IR_O_A    (ir_o_a),
    .REG_IR_O_AV   (ir_o_av),
    .REG_IR_O_BUSY (ir_o_busy),
    .REG_IW_I_EN   (iw_en),
    .REG_IW_I_A    (iw_a),
    .REG_IW_I_AV   (iw_av),
    .REG_RSV_I_EN  (rsv_en),
    .REG_RSV_I_A   (rsv_a)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    int          port;
    bit          is_addr;
    logic [31:0] av;
    logic        busy;
    logic [4:0]  a;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic exp_rd(input int c, input int p, input logic [31:0] av,
                        input logic b, input string nm);
    exp_t e;
    e.c = c; e.port = p; e.is_addr = 1'b0; e.av = av; e.busy = b; e.a = '0;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic exp_addr(input int c, input int p, input logic [4:0] a,
                          input string nm);
    exp_t e;
    e.c = c; e.port = p; e.is_addr = 1'b1; e.av = '0; e.busy = 1'b0; e.a = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: samples DUT outputs on the falling edge and retires due entries.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      exp_t  e;
      string nm;
      logic [31:0] got_av;
      logic        got_b;
      logic [4:0]  got_a;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      got_av = ir_o_av[e.port*32 +: 32];
      got_b  = ir_o_busy[e.port];
      got_a  = ir_o_a[e.port*5 +: 5];
      total++;
      if (e.c != cyc) begin
        bad++;
        $display("FAIL %s: expected at cycle %0d, sampled at cycle %0d", nm, e.c, cyc);
      end else if (e.is_addr) begin
        if (got_a !== e.a) begin
          bad++;
          $display("FAIL %s: port%0d addr got %0d want %0d", nm, e.port, got_a, e.a);
        end
      end else if (got_av !== e.av || got_b !== e.busy) begin
        bad++;
        $display("FAIL %s: port%0d av/busy got %h/%b want %h/%b",
                 nm, e.port, got_av, got_b, e.av, e.busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; stall = 0; iw_en = '0; iw_a = '0; iw_av = '0;
    rsv_en = 0; rsv_a = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    iw_en[p] = 1'b1;
    iw_a[p*5 +: 5] = a;
    iw_av[p*32 +: 32] = d;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    ir_i_a = {a1, a0};
  endtask

  initial begin
    rst = 1; idle_inputs(); ir_i_a = '0;
    tick();
    // reset state
    rd(5'd5, 5'd5);
    exp_rd(cyc, 0, 32'h0, 1'b0, "reset_av0");
    exp_addr(cyc, 0, 5'd0, "reset_addr0");
    tick();
    rst = 0;

    // basic write / read
    wr(0, 5'd5, 32'hDEADBEEF); rd(5'd0, 5'd0);
    tick(); idle_inputs();
    rd(5'd5, 5'd0);
    exp_rd(cyc + 1, 0, 32'hDEADBEEF, 1'b0, "basic_x5");
    exp_addr(cyc + 1, 0, 5'd5, "basic_addr");
    tick();

    // register 0: write and reserve are ignored
    wr(0, 5'd0, 32'hFFFFFFFF); rsv_en = 1; rsv_a = 5'd0; rd(5'd0, 5'd0);
    exp_rd(cyc, 1, 32'h0, 1'b0, "x0_same_cycle");
    tick(); idle_inputs();
    exp_rd(cyc, 0, 32'h0, 1'b0, "x0_read");

    // dual-write collision: port 1 wins
    wr(0, 5'd7, 32'd1); wr(1, 5'd7, 32'd2); rd(5'd7, 5'd0);
    tick(); idle_inputs();
    exp_rd(cyc, 0, 32'd2, 1'b0, "collision_x7");

    // scoreboard
    rd(5'd3, 5'd3); rsv_en = 1; rsv_a = 5'd3;
    tick(); idle_inputs();
    exp_rd(cyc, 0, 32'h0, 1'b1, "rsv_x3_p0");
    exp_rd(cyc, 1, 32'h0, 1'b1, "rsv_x3_p1");
    wr(0, 5'd3, 32'h10);
    exp_rd(cyc, 0, BYP ? 32'h10 : 32'h0, !BYP, "wb_x3_same_cycle");
    tick(); idle_inputs();
    exp_rd(cyc, 0, 32'h10, 1'b0, "wb_x3_after");
    wr(0, 5'd3, 32'h20); rsv_en = 1; rsv_a = 5'd3;
    tick(); idle_inputs();
    exp_rd(cyc, 0, 32'h20, 1'b1, "rsv_wins_x3");

    // stall / flush
    rd(5'd4, 5'd0);
    tick();
    stall = 1; rd(5'd9, 5'd9); rsv_en = 1; rsv_a = 5'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      rsv_en = 0;
      exp_addr(cyc, 0, 5'd4, "stall_hold");
    end
    flush = 1; rsv_en = 1; rsv_a = 5'd9;
    tick(); idle_inputs();
    exp_addr(cyc, 0, 5'd0, "flush_addr0");
    exp_addr(cyc, 1, 5'd0, "flush_addr1");
    rd(5'd9, 5'd3);
    tick();
    exp_rd(cyc, 0, 32'h0, 1'b1, "flush_rsv_x9");
    exp_rd(cyc, 1, 32'h20, 1'b0, "flush_clr_x3");
    rd(5'd6, 5'd6);
    tick();
    exp_rd(cyc, 0, 32'h0, 1'b0, "flush_clr_x6");

    // bypass behaviour
    wr(0, 5'd8, 32'h11); rd(5'd8, 5'd8);
    tick(); idle_inputs();
    wr(0, 5'd8, 32'h55);
    exp_rd(cyc, 0, BYP ? 32'h55 : 32'h11, 1'b0, "byp_x8_same");
    tick(); idle_inputs();
    exp_rd(cyc, 0, 32'h55, 1'b0, "byp_x8_after");
    wr(0, 5'd8, 32'h66); wr(1, 5'd8, 32'h77);
    exp_rd(cyc, 1, BYP ? 32'h77 : 32'h55, 1'b0, "byp_x8_dual");
    tick(); idle_inputs();
    exp_rd(cyc, 1, 32'h77, 1'b0, "byp_x8_dual_after");

    // asynchronous reset mid-run with a coincident write and reserve
    rd(5'd5, 5'd10);
    tick();
    wr(0, 5'd5, 32'h99); rsv_en = 1; rsv_a = 5'd10;
    rst = 1;
    exp_rd(cyc, 0, 32'h0, 1'b0, "rst_av0");
    exp_rd(cyc, 1, 32'h0, 1'b0, "rst_av1");
    exp_addr(cyc, 0, 5'd0, "rst_addr0");
    tick();
    idle_inputs(); rst = 0;
    tick();
    exp_rd(cyc, 0, 32'h0, 1'b0, "post_rst_x5");
    exp_rd(cyc, 1, 32'h0, 1'b0, "post_rst_x10");

    // drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count, a power of two from 2 to 64; AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, read-port count, 1 to 4.
REQ-004 SHALL have parameter NWR, default 1, write-port count, 1 to 2.
REQ-005 SHALL have port CLK  in  1  single clock, rising edge.
REQ-006 SHALL have port RST  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have ports FLUSH  in  1  pipeline flush; STALL  in  1  pipeline stall.
REQ-008 SHALL have port REG_IR_I_A  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
REQ-009 SHALL have ports REG_IR_O_A  out  NRD*AW  captured addresses; REG_IR_O_AV  out  NRD*XLEN  read values; REG_IR_O_BUSY  out  NRD  pending-write flag per port.
REQ-010 SHALL have ports REG_IW_I_EN  in  NWR  write enables; REG_IW_I_A  in  NWR*AW  write addresses; REG_IW_I_AV  in  NWR*XLEN  write data.
REQ-011 SHALL have ports REG_RSV_I_EN  in  1  reserve strobe; REG_RSV_I_A  in  AW  destination register to mark pending.

Function
REQ-012 SHALL treat register 0 as hardwired zero: it always reads 0, ignores writes and ignores reserves, and busy[0] is always 0.
REQ-013 SHALL capture REG_IR_I_A into the address registers on each rising edge when STALL=0 and FLUSH=0.
REQ-014 SHALL clear all captured addresses to 0 on a FLUSH edge; FLUSH SHALL take priority over STALL.
REQ-015 SHALL hold the captured addresses on an edge where STALL=1 and FLUSH=0.
REQ-016 SHALL drive REG_IR_O_A directly from the captured addresses.
REQ-017 SHALL drive REG_IR_O_AV and REG_IR_O_BUSY combinationally from the captured address, giving one cycle of latency from address input to value.
REQ-018 SHALL write REG_IW_I_AV[j] into register REG_IW_I_A[j] on a rising edge when REG_IW_I_EN[j]=1 and the address is not 0; writes SHALL be unaffected by STALL and FLUSH.
REQ-019 SHALL, when both write ports target the same nonzero address in one cycle, store the data from port 1 (the higher index wins).
REQ-020 SHALL hold a busy bit per register in the scoreboard: REG_RSV_I_EN sets busy[REG_RSV_I_A], and any enabled write clears busy at its address.
REQ-021 SHALL, when a reserve and a write target the same address in the same cycle, leave busy set (the reserve wins).
REQ-022 SHALL clear all busy bits on a FLUSH edge, except that a reserve in the same cycle still sets its bit.
REQ-023 SHALL support any number of read ports selecting the same register, each returning an identical value.

Reset
REQ-024 SHALL, while RST=1, asynchronously clear all registers, all captured addresses and all busy bits to 0.
REQ-025 SHALL, consequently, drive REG_IR_O_A=0, REG_IR_O_AV=0 and REG_IR_O_BUSY=0 during reset.
REQ-026 SHALL discard an in-flight write or reserve that coincides with RST.

Configuration
REQ-027 SHALL use the macro REGFILE_MP_BYPASS_EN to control write-to-read forwarding.
REQ-028 SHALL, with REGFILE_MP_BYPASS_EN defined, forward an enabled same-cycle write to REG_IR_O_AV when its address matches a captured address (not 0), and report busy=0 for that port; port 1 wins over port 0.
REQ-029 SHALL, without REGFILE_MP_BYPASS_EN, return the array contents only, so new data appears on the cycle after the write edge.

Structure
REQ-030 SHALL place the parameter defaults, the AW derivation function and the port-slice width constants in the shared package/header regfile_pkg.
REQ-031 SHALL implement the busy-bit array and its set/clear/flush priority in the sub-module regfile_scoreboard, instantiated once.

Verification
REQ-032 SHALL verify basic write/read: write x5=0xDEADBEEF, then read x5 on port 0 -> REG_IR_O_AV=0xDEADBEEF one cycle after the address.
REQ-033 SHALL verify register 0: write x0=0xFFFFFFFF and reserve x0 -> reads 0 and busy=0.
REQ-034 SHALL verify dual-write collision (NWR=2): port 0 writes x7=1 and port 1 writes x7=2 in one cycle -> x7 reads 2.
REQ-035 SHALL verify the scoreboard: reserve x3 -> busy=1 on a port reading x3; writeback x3=0x10 -> busy=0; reserve and write x3 in the same cycle -> busy=1.
REQ-036 SHALL verify STALL/FLUSH: capture address 4, hold STALL for 3 cycles while presenting address 9 -> REG_IR_O_A stays 4; FLUSH -> REG_IR_O_A=0 and all busy=0.
REQ-037 SHALL verify bypass: read x8 while x8 is being written with 0x55 -> 0x55 in the same cycle with REGFILE_MP_BYPASS_EN, and the old value then 0x55 without it; assert RST mid-test -> all outputs 0 immediately.
